// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill
// from a one-word-per-ack backing memory and saturating read hit/miss counters.
module data_cache #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;
  localparam int AW    = INDEX_BITS + OFFSET_BITS;
  localparam int TAG_W = 32 - AW;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESPOND} state_t;
  state_t state, state_nx;

  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tags  [LINES];
  logic [31:0]            words [LINES*WORDS];
  logic [31:0]            laddr, ldata;
  logic                   lhit;
  logic [OFFSET_BITS-1:0] beat;

  logic [INDEX_BITS-1:0]  req_idx, l_idx;
  logic [AW-1:0]          req_word, l_word;
  logic                   lookup_hit, last_beat;
  logic                   latch, cnt_hit, cnt_miss, refill_ack, write_ack;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign req_idx    = cpu_addr[AW-1:OFFSET_BITS];
  assign req_word   = cpu_addr[AW-1:0];
  assign l_idx      = laddr[AW-1:OFFSET_BITS];
  assign l_word     = laddr[AW-1:0];
  assign lookup_hit = valid[req_idx] && (tags[req_idx] == cpu_addr[31:AW]);
  assign last_beat  = (beat == OFFSET_BITS'(WORDS - 1));

  always_comb begin
    state_nx   = state;
    cpu_busy   = 1'b0;
    cpu_done   = 1'b0;
    cpu_rdata  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    latch      = 1'b0;
    cnt_hit    = 1'b0;
    cnt_miss   = 1'b0;
    refill_ack = 1'b0;
    write_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_busy = 1'b1;
            latch    = 1'b1;
            state_nx = WRITE;
          end else if (lookup_hit) begin
            cpu_done  = 1'b1;
            cpu_rdata = words[req_word];
            cnt_hit   = 1'b1;
          end else begin
            cpu_busy = 1'b1;
            latch    = 1'b1;
            cnt_miss = 1'b1;
            state_nx = REFILL;
          end
        end
      end
      REFILL: begin
        cpu_busy   = 1'b1;
        mem_req    = 1'b1;
        mem_addr   = {laddr[31:OFFSET_BITS], beat};
        refill_ack = mem_ack;
        if (mem_ack && last_beat) state_nx = RESPOND;
      end
      WRITE: begin
        cpu_busy  = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = laddr;
        mem_wdata = ldata;
        write_ack = mem_ack;
        if (mem_ack) state_nx = RESPOND;
      end
      RESPOND: begin
        cpu_done  = 1'b1;
        cpu_rdata = words[l_word];
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Outputs and side effects are forced quiet the moment reset asserts,
    // independent of the clock.
    if (!reset) begin
      cpu_busy   = 1'b0;
      cpu_done   = 1'b0;
      cpu_rdata  = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      latch      = 1'b0;
      cnt_hit    = 1'b0;
      cnt_miss   = 1'b0;
      refill_ack = 1'b0;
      write_ack  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      valid      <= '0;
      beat       <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nx;
      if (cnt_hit) hit_count <= sat_inc(hit_count);
      if (cnt_miss) begin
        miss_count <= sat_inc(miss_count);
        beat       <= '0;
      end
      if (refill_ack) begin
        beat <= beat + 1'b1;
        if (last_beat) valid[l_idx] <= 1'b1;
      end
    end
  end

  // Request latch and line storage carry no reset; valid bits guard their use.
  always_ff @(posedge clock) begin
    if (latch) begin
      laddr <= cpu_addr;
      ldata <= cpu_wdata;
      lhit  <= lookup_hit;
    end
    if (refill_ack) begin
      words[{l_idx, beat}] <= mem_rdata;
      if (last_beat) tags[l_idx] <= laddr[31:AW];
    end
    if (write_ack && lhit) words[l_word] <= ldata;
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized
// accesses checked cycle by cycle against a resident-line/backing-memory model.
module tb_data_cache;
  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_busy, cpu_done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count, miss_count;

  int tests = 0;
  int fails = 0;

  // Model: backing memory, which line each index currently holds, counters.
  logic [31:0] bmem [logic [31:0]];
  logic        res_valid [16];
  logic [29:0] res_line  [16];
  logic [31:0] m_hits, m_misses;

  data_cache #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_value(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) res_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_hit_count"}, hit_count, m_hits);
    chk({tag, "_miss_count"}, miss_count, m_misses);
  endtask

  // Performs one CPU access, starting just after a falling edge, and checks the
  // DUT every cycle. ack_dly < 0 picks a random 0..3 cycle memory latency.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_dly, output logic [31:0] rd);
    int          idx    = int'(addr[5:2]);
    logic        hit    = !we && res_valid[idx] && (res_line[idx] == addr[31:2]);
    int          nbeats = we ? 1 : (hit ? 0 : 4);
    int          beat_i = 0;
    int          wait_c = 0;
    int          dly;
    bit          done_seen = 0;
    logic [31:0] exp_a;
    rd  = '0;
    dly = (ack_dly < 0) ? int'($urandom_range(3, 0)) : ack_dly;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      #1;
      if (c == 0 && hit) begin
        chk("hit_done", {31'd0, cpu_done}, 32'd1);
        chk("hit_busy", {31'd0, cpu_busy}, 32'd0);
        chk("hit_memreq", {31'd0, mem_req}, 32'd0);
        chk("hit_rdata", cpu_rdata, mem_value(addr));
        rd = cpu_rdata;
        done_seen = 1;
      end else if (c == 0) begin
        chk("start_busy", {31'd0, cpu_busy}, 32'd1);
        chk("start_done", {31'd0, cpu_done}, 32'd0);
        chk("start_memreq", {31'd0, mem_req}, 32'd0);
      end else if (beat_i < nbeats) begin
        exp_a = we ? addr : {addr[31:2], 2'(beat_i)};
        chk("beat_memreq", {31'd0, mem_req}, 32'd1);
        chk("beat_busy", {31'd0, cpu_busy}, 32'd1);
        chk("beat_done", {31'd0, cpu_done}, 32'd0);
        chk("beat_memwe", {31'd0, mem_we}, {31'd0, we});
        chk("beat_addr", mem_addr, exp_a);
        if (we) chk("beat_wdata", mem_wdata, wdata);
        if (wait_c == dly) begin
          mem_ack   = 1'b1;
          mem_rdata = we ? 32'h0 : mem_value(exp_a);
          if (we) bmem[addr] = wdata;
          beat_i++;
          wait_c = 0;
          dly = (ack_dly < 0) ? int'($urandom_range(3, 0)) : ack_dly;
        end else begin
          wait_c++;
        end
      end else begin
        chk("resp_done", {31'd0, cpu_done}, 32'd1);
        chk("resp_busy", {31'd0, cpu_busy}, 32'd0);
        chk("resp_memreq", {31'd0, mem_req}, 32'd0);
        if (!we) chk("resp_rdata", cpu_rdata, mem_value(addr));
        rd = cpu_rdata;
        done_seen = 1;
      end
      @(posedge clock);
      @(negedge clock);
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      if (done_seen) cpu_req = 1'b0;
    end
    if (!done_seen) begin
      tests++; fails++;
      $display("FAIL access_timeout: addr 0x%08h never completed", addr);
      cpu_req = 1'b0;
    end
    if (!we && hit) m_hits++;
    if (!we && !hit) begin
      m_misses++;
      res_valid[idx] = 1'b1;
      res_line[idx]  = addr[31:2];
    end
    check_counts("post");
  endtask

  task automatic idle_cycles(input int n);
    cpu_req = 1'b0;
    cpu_addr = $urandom;
    cpu_we = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("idle_busy", {31'd0, cpu_busy}, 32'd0);
      chk("idle_done", {31'd0, cpu_done}, 32'd0);
      chk("idle_memreq", {31'd0, mem_req}, 32'd0);
      @(negedge clock);
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit          hit_beat2;
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 0; cpu_wdata = 0;
    mem_ack = 1'b0; mem_rdata = 0;
    model_reset();
    for (int b = 0; b < 4; b++) bmem[32'h10 + b] = 32'hA0 + b;
    repeat (3) @(negedge clock);
    cpu_req = 1'b1;
    #1;
    chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_memaddr", mem_addr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    cpu_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Directed scenarios with hand-computed results.
    access(1'b0, 32'h10, 32'h0, 0, rd);
    chk("d_read10_rdata", rd, 32'hA0);
    chk("d_read10_misses", miss_count, 32'd1);
    access(1'b0, 32'h12, 32'h0, 0, rd);
    chk("d_read12_rdata", rd, 32'hA2);
    chk("d_read12_hits", hit_count, 32'd1);
    access(1'b1, 32'h11, 32'hDEADBEEF, 3, rd);
    access(1'b0, 32'h11, 32'h0, 0, rd);
    chk("d_read11_rdata", rd, 32'hDEADBEEF);
    access(1'b0, 32'h50, 32'h0, 0, rd);
    access(1'b0, 32'h10, 32'h0, 0, rd);
    chk("d_conflict_misses", miss_count, 32'd3);
    chk("d_conflict_hits", hit_count, 32'd2);
    chk("d_conflict_rdata", rd, 32'hA0);

    // Reset pulsed during the third refill beat.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h54;
    hit_beat2 = 0;
    for (int c = 0; c < 20 && !hit_beat2; c++) begin
      #1;
      if (mem_req && mem_addr == 32'h56) hit_beat2 = 1;
      else begin
        mem_ack = mem_req;
        mem_rdata = mem_value(mem_addr);
        @(negedge clock);
        mem_ack = 1'b0;
      end
    end
    chk("r_reached_beat2", {31'd0, hit_beat2}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("r_memreq", {31'd0, mem_req}, 32'd0);
    chk("r_busy", {31'd0, cpu_busy}, 32'd0);
    chk("r_hits", hit_count, 32'd0);
    chk("r_misses", miss_count, 32'd0);
    @(negedge clock);
    cpu_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    access(1'b0, 32'h10, 32'h0, 1, rd);
    chk("r_read10_misses", miss_count, 32'd1);
    chk("r_read10_rdata", rd, 32'hA0);

    // Write miss: memory updated, no allocation.
    access(1'b1, 32'h30, 32'h1234_5678, 1, rd);
    chk("w_miss_mem", bmem[32'h30], 32'h1234_5678);
    access(1'b0, 32'h30, 32'h0, 0, rd);
    chk("w_miss_then_read_misses", miss_count, 32'd2);
    chk("w_miss_then_read_rdata", rd, 32'h1234_5678);

    // Randomized traffic over four tags so hits, misses and conflicts mix.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a = {24'd0, 8'($urandom)};
      if ($urandom_range(3, 0) == 0) idle_cycles(int'($urandom_range(2, 1)));
      if ($urandom_range(9, 0) < 3) access(1'b1, a, $urandom, -1, rd);
      else access(1'b0, a, 32'h0, -1, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
